load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-side load/store unit between the processor core's data port and the data memory bus. Captures one core access, builds the word-aligned bus address, byte enables and lane-replicated write data, runs the request/grant/valid handshake, and returns sign- or zero-extended load data to the core. It also enforces an access timeout, and optionally checks alignment.

## Interface
- TIMEOUT, 255: max cycles from the first bus-request cycle (in ADDR) to mem_r_valid; 0 disables the timeout.
- CLK  in  1  clock; everything updates on the rising edge.
- RES  in  1  reset, asynchronous, active-high.
- core_req  in  1  access request, held until core_r_valid.
- core_we  in  1  1 = store, 0 = load.
- core_size  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- core_unsigned  in  1  funct3[2]: zero-extend load data.
- core_adr  in  32  byte address (ALU result).
- core_wdata  in  32  store data, right-aligned.
- core_gnt  out  1  one-cycle pulse: bus accepted the address.
- core_r_valid  out  1  one-cycle pulse: access complete.
- core_rdata  out  32  formatted load data, valid with core_r_valid.
- core_err  out  1  valid with core_r_valid: access failed.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_adr  out  32  {adr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  bus grant.
- mem_r_valid  in  1  bus response valid, also returned for stores.
- mem_rdata  in  32  bus read data.

## Operation
- FSM states are IDLE, ADDR, RESP and DONE.
- IDLE:
  - On core_req=1, register we, size, unsigned, adr[1:0] and the formatted bus fields.
  - Legal access: go to ADDR. Illegal access: go to DONE with err=1.
- ADDR:
  - mem_req=1 with mem_we, mem_adr, mem_be and mem_wdata held constant.
  - On mem_gnt: pulse core_gnt the same cycle, go to RESP.
- RESP:
  - mem_req=0.
  - On mem_r_valid: register the formatted mem_rdata, go to DONE with err=0.
- DONE:
  - core_r_valid=1 for exactly one cycle, with core_err, then IDLE.
  - core_req is ignored in DONE, so the earliest new capture is the cycle after core_r_valid.
- Byte enables: byte → 4'b0001<<adr[1:0]; half → 4'b0011<<{adr[1],1'b0}; word → 4'b1111.
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata unchanged.
- Load data:
  - Extract the lane selected by the same offsets, then sign-extend from bit 7 or 15, or zero-extend if core_unsigned.
  - Word loads ignore core_unsigned.
  - Stores return core_rdata=0.
- Timeout:
  - Counter clears on capture and increments every cycle in ADDR and RESP.
  - On reaching TIMEOUT: drop mem_req, go to DONE with err=1 and core_rdata=0.
  - A late mem_r_valid (arriving in IDLE or DONE) is ignored.
- size=11 is always illegal: no bus access, err=1.

## Timing
- Reset value of every output is 0, including mem_adr, mem_be and mem_wdata. FSM → IDLE, counter → 0.
- Reset mid-access aborts the access; the bus sees mem_req fall asynchronously.
- Minimum latency, with mem_gnt granted immediately and mem_r_valid one cycle later:
  - cycle 0: core_req sampled.
  - cycle 1: mem_req and mem_gnt.
  - cycle 2: mem_r_valid.
  - cycle 3: core_r_valid.
- Illegal access: core_r_valid (with core_err=1) in cycle 1, no mem_req.
- mem_gnt and mem_r_valid in the same cycle while in ADDR: treated as grant only. The response must come in a later cycle.
- Timeout expiring in the same cycle as mem_r_valid (RESP): the response wins, err=0.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - A half access with adr[0]=1, or a word access with adr[1:0]≠0, is illegal: no bus access, core_err=1.
- Undefined:
  - Offending low address bits are ignored. Half uses adr[1] only; word uses offset 0.
  - The access proceeds normally with err=0.

## Test plan
- Word store, adr=0x1C00_0104, wdata=0xDEADBEEF, immediate gnt, r_valid next cycle → mem_be=1111, mem_adr=0x1C00_0104, core_r_valid in cycle 3, err=0.
- Byte load, adr=…03, mem_rdata=0x80FF_1234, signed → core_rdata=0xFFFF_FF80; unsigned → 0x0000_0080.
- Half store, adr=…02, wdata=0x0000_ABCD → mem_be=1100, mem_wdata=0xABCD_ABCD. Insert 3 wait cycles before mem_gnt → mem_req held stable for all of them.
- Half load, adr=…01, with LSU_ALIGN_CHECK_EN → core_r_valid and err=1 in cycle 1, mem_req never 1. Without the macro → lane 0 read, err=0.
- TIMEOUT=4 and mem_r_valid never asserted → core_r_valid with err=1 and core_rdata=0 after 4 cycles. A later stray mem_r_valid → no output pulse.
- RES pulse during RESP → all outputs 0 immediately. The next core_req completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side and memory-side bus bundles for load_store_unit.
// Core drives requests through lsu_core_if; the LSU masters the data bus through lsu_mem_if.
interface lsu_core_if;
    logic        core_req;
    logic        core_we;
    logic [1:0]  core_size;
    logic        core_unsigned;
    logic [31:0] core_adr;
    logic [31:0] core_wdata;
    logic        core_gnt;
    logic        core_r_valid;
    logic [31:0] core_rdata;
    logic        core_err;

    modport master (
        output core_req, core_we, core_size, core_unsigned, core_adr, core_wdata,
        input  core_gnt, core_r_valid, core_rdata, core_err
    );
    modport slave (
        input  core_req, core_we, core_size, core_unsigned, core_adr, core_wdata,
        output core_gnt, core_r_valid, core_rdata, core_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_r_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_adr, mem_be, mem_wdata,
        input  mem_gnt, mem_r_valid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_adr, mem_be, mem_wdata,
        output mem_gnt, mem_r_valid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-side load/store unit: one access at a time, req/gnt/r_valid bus handshake with timeout.
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of truncating the offset.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RES,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        adr_q, adr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               misaligned;
    logic               illegal;
    logic               timeout_hit;
    logic [1:0]         off_in;
    logic               gnt_out;
    logic               req_out;

    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   be_of = 4'b0001 << off;
            2'b01:   be_of = 4'b0011 << off;
            2'b10:   be_of = 4'b1111;
            default: be_of = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   wdata_of = {4{wd[7:0]}};
            2'b01:   wdata_of = {2{wd[15:0]}};
            default: wdata_of = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] lane;
        lane = rd >> {off, 3'b000};
        case (size)
            2'b00:   load_fmt = uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_fmt = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_fmt = rd;
        endcase
    endfunction

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((core.core_size == 2'b01) && core.core_adr[0]) ||
                        ((core.core_size == 2'b10) && (core.core_adr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign illegal     = (core.core_size == 2'b11) || misaligned;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Lane offset actually used on the bus: halves drop adr[0], words drop both low bits.
    always_comb begin
        case (core.core_size)
            2'b00:   off_in = core.core_adr[1:0];
            2'b01:   off_in = {core.core_adr[1], 1'b0};
            default: off_in = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        adr_d   = adr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        gnt_out = 1'b0;
        req_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (core.core_req) begin
                    we_d    = core.core_we;
                    size_d  = core.core_size;
                    uns_d   = core.core_unsigned;
                    off_d   = off_in;
                    adr_d   = {core.core_adr[31:2], 2'b00};
                    be_d    = be_of(core.core_size, off_in);
                    wdata_d = wdata_of(core.core_size, core.core_wdata);
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    err_d   = illegal;
                    state_d = illegal ? DONE : ADDR;
                end
            end
            ADDR: begin
                req_out = 1'b1;
                gnt_out = mem.mem_gnt;
                cnt_d   = cnt_q + 1'b1;
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (mem.mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 1'b1;
                // A response arriving on the expiry cycle still completes the access.
                if (mem.mem_r_valid) begin
                    rdata_d = we_q ? 32'h0 : load_fmt(size_q, uns_q, off_q, mem.mem_rdata);
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            adr_q   <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            adr_q   <= adr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign core.core_gnt     = gnt_out;
    assign core.core_r_valid = (state_q == DONE);
    assign core.core_rdata   = rdata_q;
    assign core.core_err     = err_q;
    assign mem.mem_req       = req_out;
    assign mem.mem_we        = we_q;
    assign mem.mem_adr       = adr_q;
    assign mem.mem_be        = be_q;
    assign mem.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level reference model and directed corner cases.
module tb_load_store_unit;

    localparam int TMO = 6;

    logic CLK = 1'b0;
    logic RES;
    always #5 CLK = ~CLK;

    lsu_core_if cif();
    lsu_mem_if  mif();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .CLK  (CLK),
        .RES  (RES),
        .core (cif.slave),
        .mem  (mif.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_t0     = 0;

    bit          check_en = 1'b0;
    logic        exp_req, exp_gnt, exp_rv, exp_err, exp_chk_rdata, exp_we;
    logic [31:0] exp_adr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    logic [31:0] obs_adr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_err;
    int          obs_rv_cyc  = 0;
    int          obs_req_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            check("mem_req", 32'(mif.mem_req), 32'(exp_req));
            check("core_gnt", 32'(cif.core_gnt), 32'(exp_gnt));
            check("core_r_valid", 32'(cif.core_r_valid), 32'(exp_rv));
            if (exp_req) begin
                check("mem_adr", mif.mem_adr, exp_adr);
                check("mem_be", 32'(mif.mem_be), 32'(exp_be));
                check("mem_wdata", mif.mem_wdata, exp_wdata);
                check("mem_we", 32'(mif.mem_we), 32'(exp_we));
            end
            if (exp_rv) begin
                check("core_err", 32'(cif.core_err), 32'(exp_err));
                if (exp_chk_rdata) check("core_rdata", cif.core_rdata, exp_rdata);
            end
        end
        if (mif.mem_req) begin
            obs_req_cnt <= obs_req_cnt + 1;
            obs_adr     <= mif.mem_adr;
            obs_be      <= mif.mem_be;
            obs_wdata   <= mif.mem_wdata;
        end
        if (cif.core_r_valid) begin
            obs_rv_cyc <= cyc;
            obs_rdata  <= cif.core_rdata;
            obs_err    <= cif.core_err;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle_exp();
        exp_req = 1'b0; exp_gnt = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_chk_rdata = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, 32'(mif.mem_req), 32'h0);
        check({tag, "_mem_we"}, 32'(mif.mem_we), 32'h0);
        check({tag, "_mem_adr"}, mif.mem_adr, 32'h0);
        check({tag, "_mem_be"}, 32'(mif.mem_be), 32'h0);
        check({tag, "_mem_wdata"}, mif.mem_wdata, 32'h0);
        check({tag, "_core_gnt"}, 32'(cif.core_gnt), 32'h0);
        check({tag, "_core_r_valid"}, 32'(cif.core_r_valid), 32'h0);
        check({tag, "_core_rdata"}, cif.core_rdata, 32'h0);
        check({tag, "_core_err"}, 32'(cif.core_err), 32'h0);
    endtask

    // gw: wait cycles before grant; rw: cycles from grant to response, negative = never.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] adr, input logic [31:0] wd, input logic [31:0] rd,
                           input int gw, input int rw, input bit same, input bit stray, input int gap);
        logic        legal;
        int          off, nb, gn, rvn, endn;
        bit          tmo;
        logic [31:0] ld, ewd;
        logic [3:0]  ebe;

        legal = (size != 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
        if (size == 2'b01 && adr[0]) legal = 1'b0;
        if (size == 2'b10 && adr[1:0] != 2'b00) legal = 1'b0;
`endif
        nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off = (size == 2'b00) ? int'(adr[1:0]) : (size == 2'b01) ? 2 * int'(adr[1]) : 0;
        ebe = 4'h0; ewd = 32'h0; ld = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ebe[i]        = (i >= off) && (i < off + nb);
            ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        for (int i = 0; i < nb; i++) ld[8*i +: 8] = rd[8*(off + i) +: 8];
        if (nb < 4 && !uns && ld[8*nb - 1])
            for (int i = nb; i < 4; i++) ld[8*i +: 8] = 8'hFF;
        if (we) ld = 32'h0;

        last_t0 = cyc;
        cif.core_req = 1'b1; cif.core_we = we; cif.core_size = size;
        cif.core_unsigned = uns; cif.core_adr = adr; cif.core_wdata = wd;
        idle_exp();
        exp_adr = {adr[31:2], 2'b00}; exp_be = ebe; exp_wdata = ewd; exp_we = we;
        step();
        if (!legal) begin
            exp_rv = 1'b1; exp_err = 1'b1; exp_chk_rdata = 1'b0;
            mif.mem_r_valid = stray;
            step();
        end else begin
            gn   = gw + 1;
            rvn  = (rw < 0) ? (1 << 30) : gn + rw;
            tmo  = (TMO != 0) && (gn >= TMO || rvn > TMO);
            endn = tmo ? TMO : rvn;
            for (int n = 1; n <= endn; n++) begin
                exp_req = (n <= gn);
                exp_gnt = (n == gn);
                mif.mem_gnt     = (n == gn);
                mif.mem_r_valid = (n == rvn) || (same && n == gn);
                mif.mem_rdata   = (n == rvn) ? rd : ~rd;
                step();
            end
            mif.mem_gnt = 1'b0; mif.mem_r_valid = stray; mif.mem_rdata = $urandom;
            exp_req = 1'b0; exp_gnt = 1'b0; exp_rv = 1'b1; exp_err = tmo;
            exp_rdata = tmo ? 32'h0 : ld; exp_chk_rdata = 1'b1;
            step();
        end
        cif.core_req = 1'b0;
        mif.mem_r_valid = 1'b0;
        idle_exp();
        for (int g = 0; g < gap; g++) begin
            mif.mem_r_valid = 1'($urandom_range(0, 1));
            step();
        end
        mif.mem_r_valid = 1'b0;
    endtask

    initial begin
        int base_req;
        RES = 1'b1;
        cif.core_req = 1'b0; cif.core_we = 1'b0; cif.core_size = 2'b00;
        cif.core_unsigned = 1'b0; cif.core_adr = 32'h0; cif.core_wdata = 32'h0;
        mif.mem_gnt = 1'b0; mif.mem_r_valid = 1'b0; mif.mem_rdata = 32'h0;
        idle_exp();
        exp_we = 1'b0; exp_adr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
        #2;
        check_all_zero("reset");
        step(); step();
        RES = 1'b0;
        step();
        check_en = 1'b1;

        // Word store, minimum latency.
        run_txn(1'b1, 2'b10, 1'b0, 32'h1C00_0104, 32'hDEAD_BEEF, 32'h0, 0, 1, 1'b0, 1'b0, 1);
        check("ws_be", 32'(obs_be), 32'h0000_000F);
        check("ws_adr", obs_adr, 32'h1C00_0104);
        check("ws_wdata", obs_wdata, 32'hDEAD_BEEF);
        check("ws_latency", 32'(obs_rv_cyc - last_t0), 32'd3);
        check("ws_err", 32'(obs_err), 32'h0);

        // Byte loads, signed then unsigned.
        run_txn(1'b0, 2'b00, 1'b0, 32'h1C00_0003, 32'h0, 32'h80FF_1234, 0, 1, 1'b0, 1'b0, 0);
        check("lb_signed", obs_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 2'b00, 1'b1, 32'h1C00_0003, 32'h0, 32'h80FF_1234, 0, 1, 1'b0, 1'b1, 1);
        check("lb_unsigned", obs_rdata, 32'h0000_0080);

        // Half store with three grant wait cycles; simultaneous gnt/r_valid is grant only.
        run_txn(1'b1, 2'b01, 1'b0, 32'h1C00_0002, 32'h0000_ABCD, 32'h0, 3, 1, 1'b1, 1'b0, 1);
        check("sh_be", 32'(obs_be), 32'h0000_000C);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);

        // Misaligned half load.
        base_req = obs_req_cnt;
        run_txn(1'b0, 2'b01, 1'b0, 32'h1C00_0001, 32'h0, 32'h1234_8001, 0, 1, 1'b0, 1'b0, 1);
`ifdef LSU_ALIGN_CHECK_EN
        check("mis_err", 32'(obs_err), 32'h1);
        check("mis_latency", 32'(obs_rv_cyc - last_t0), 32'd1);
        check("mis_no_req", 32'(obs_req_cnt - base_req), 32'd0);
`else
        check("mis_err", 32'(obs_err), 32'h0);
        check("mis_rdata", obs_rdata, 32'hFFFF_8001);
`endif

        // Illegal size never touches the bus.
        base_req = obs_req_cnt;
        run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0, 1);
        check("ill_err", 32'(obs_err), 32'h1);
        check("ill_no_req", 32'(obs_req_cnt - base_req), 32'd0);

        // Timeout with no response, then a stray r_valid in DONE and idle.
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 0, -1, 1'b0, 1'b1, 2);
        check("tmo_err", 32'(obs_err), 32'h1);
        check("tmo_rdata", obs_rdata, 32'h0);
        check("tmo_latency", 32'(obs_rv_cyc - last_t0), 32'(TMO + 1));

        // Response on the expiry cycle wins.
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0, 32'h1357_9BDF, 2, TMO - 3, 1'b0, 1'b0, 1);
        check("edge_err", 32'(obs_err), 32'h0);
        check("edge_rdata", obs_rdata, 32'h1357_9BDF);

        // Load leaving non-zero state, then reset during RESP.
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0031, 32'h0, 32'h0000_7700, 0, 1, 1'b0, 1'b0, 0);
        last_t0 = cyc;
        cif.core_req = 1'b1; cif.core_we = 1'b0; cif.core_size = 2'b10;
        cif.core_unsigned = 1'b0; cif.core_adr = 32'h0000_0040;
        idle_exp();
        exp_adr = 32'h0000_0040; exp_be = 4'hF; exp_we = 1'b0; exp_wdata = {4{cif.core_wdata[7:0]}};
        exp_wdata = cif.core_wdata;
        step();
        exp_req = 1'b1; exp_gnt = 1'b1; mif.mem_gnt = 1'b1;
        step();
        mif.mem_gnt = 1'b0; idle_exp();
        #2;
        check_en = 1'b0;
        RES = 1'b1;
        #1;
        check_all_zero("midreset");
        step();
        RES = 1'b0;
        cif.core_req = 1'b0;
        idle_exp();
        step();
        check_en = 1'b1;
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0046, 32'h0, 32'hC001_0000, 1, 2, 1'b0, 1'b0, 1);
        check("post_reset_rdata", obs_rdata, 32'hFFFF_C001);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            logic        we, uns;
            logic [1:0]  size;
            int          gw, rw;
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            gw   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            rw   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 3));
            run_txn(we, size, uns, $urandom, $urandom, $urandom, gw, rw,
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
